// File: rtl/rx_des_param.sv
// UART-style frame deserializer: dual-rate baud counter, 3-sample majority vote, idle detection.
// Optional parity bit between data and stop bit when RX_DES_PARITY_EN is defined.
module rx_des_param #(
   parameter int DATA_BITS = 8,
   parameter int IDLE_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [15:0]          div_ls,
   input  logic [15:0]          div_hs,
   input  logic [IDLE_W-1:0]    idle_wait_len,
   input  logic                 parity_odd,
   input  logic                 force_wait_idle,
   input  logic                 rx,
   output logic                 bus_idle,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_clk,
   output logic                 rx_break,
   output logic                 err_frame,
   output logic                 err_parity
);
`ifdef RX_DES_PARITY_EN
   localparam int STOP_IDX = DATA_BITS + 2;
`else
   localparam int STOP_IDX = DATA_BITS + 1;
`endif
   localparam int BCW = $clog2(STOP_IDX + 1);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS);
   localparam logic [BCW-1:0] STOP      = BCW'(STOP_IDX);

   typedef enum logic [1:0] {WAIT_IDLE = 2'd0, BUS_IDLE = 2'd1, DATA = 2'd2, WAIT_DATA = 2'd3} state_t;

   state_t               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d, div;
   logic [1:0]           rx_d_q, rx_d_d;
   logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 sel_q, sel_d, first_q, first_d;
   logic                 bus_idle_q, bus_idle_d, data_clk_q, data_clk_d;
   logic                 rx_break_q, rx_break_d, err_frame_q, err_frame_d;
   logic                 inc, cap, smp, sync, idle_done, done, pb;

`ifdef RX_DES_PARITY_EN
   logic par_bad_q, par_bad_d, err_parity_q, err_parity_d;
   assign pb         = par_bad_q;
   assign err_parity = err_parity_q;
`else
   logic unused_parity;
   assign unused_parity = parity_odd;
   assign pb            = 1'b0;
   assign err_parity    = 1'b0;
`endif

   always_comb begin
      div       = sel_q ? div_hs : div_ls;
      inc       = (cnt_q == div);
      cap       = (cnt_q == (div >> 1));
      smp       = (rx & rx_d_q[0]) | (rx & rx_d_q[1]) | (rx_d_q[0] & rx_d_q[1]);
      sync      = (state_q == BUS_IDLE) || (state_q == WAIT_DATA && !rx);
      cnt_d     = (sync || inc) ? 16'd0 : cnt_q + 16'd1;
      rx_d_d    = {rx_d_q[0], rx};
      idle_done = (idle_cnt_q >= idle_wait_len);

      idle_cnt_d = idle_cnt_q;
      if (state_q == DATA || !rx)        idle_cnt_d = '0;
      else if (inc && idle_cnt_q != '1)  idle_cnt_d = idle_cnt_q + IDLE_W'(1);

      state_d     = state_q;
      sel_d       = sel_q;
      first_d     = first_q;
      bit_cnt_d   = bit_cnt_q;
      data_d      = data_q;
      data_clk_d  = 1'b0;
      rx_break_d  = 1'b0;
      err_frame_d = 1'b0;
      done        = 1'b0;
`ifdef RX_DES_PARITY_EN
      par_bad_d    = par_bad_q;
      err_parity_d = 1'b0;
`endif

      case (state_q)
         WAIT_IDLE: if (idle_done) state_d = BUS_IDLE;
         BUS_IDLE:  if (!rx) state_d = DATA;
         DATA: begin
            if (cap) begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == '0) begin
                  if (smp) begin
                     err_frame_d = 1'b1;
                     done        = 1'b1;
                  end
               end else if (bit_cnt_q <= LAST_DATA) begin
                  // LSB arrives first, so shift in from the top
                  data_d = {smp, data_q[DATA_BITS-1:1]};
`ifdef RX_DES_PARITY_EN
               end else if (bit_cnt_q < STOP) begin
                  if (smp != (^data_q ^ parity_odd)) par_bad_d = 1'b1;
`endif
               end else begin
                  done = 1'b1;
                  if (!smp) begin
                     if (data_q == '0 && !pb) rx_break_d  = 1'b1;
                     else                     err_frame_d = 1'b1;
                  end else if (!pb) begin
                     data_clk_d = 1'b1;
                     first_d    = 1'b0;
                  end
`ifdef RX_DES_PARITY_EN
                  else err_parity_d = 1'b1;
`endif
               end
               if (done) begin
                  bit_cnt_d = '0;
                  state_d   = data_clk_d ? WAIT_DATA : WAIT_IDLE;
               end
            end
         end
         WAIT_DATA: begin
            if (!rx) begin
               state_d = DATA;
               sel_d   = !first_q;
            end else if (idle_done) begin
               state_d = BUS_IDLE;
            end
         end
         default: state_d = WAIT_IDLE;
      endcase

      if (force_wait_idle) state_d = WAIT_IDLE;
      if (state_d == WAIT_IDLE || state_d == BUS_IDLE) begin
         sel_d   = 1'b0;
         first_d = 1'b1;
      end
      if (state_q != DATA) begin
         bit_cnt_d = '0;
`ifdef RX_DES_PARITY_EN
         par_bad_d = 1'b0;
`endif
      end
      bus_idle_d = (state_d == BUS_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAIT_IDLE;
         cnt_q       <= '0;
         rx_d_q      <= '0;
         idle_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         data_q      <= '0;
         sel_q       <= 1'b0;
         first_q     <= 1'b1;
         bus_idle_q  <= 1'b0;
         data_clk_q  <= 1'b0;
         rx_break_q  <= 1'b0;
         err_frame_q <= 1'b0;
`ifdef RX_DES_PARITY_EN
         par_bad_q    <= 1'b0;
         err_parity_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_d_q      <= rx_d_d;
         idle_cnt_q  <= idle_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         first_q     <= first_d;
         bus_idle_q  <= bus_idle_d;
         data_clk_q  <= data_clk_d;
         rx_break_q  <= rx_break_d;
         err_frame_q <= err_frame_d;
`ifdef RX_DES_PARITY_EN
         par_bad_q    <= par_bad_d;
         err_parity_q <= err_parity_d;
`endif
      end
   end

   assign bus_idle  = bus_idle_q;
   assign data      = data_q;
   assign data_clk  = data_clk_q;
   assign rx_break  = rx_break_q;
   assign err_frame = err_frame_q;
endmodule

// File: tb/tb_rx_des_param.sv
// Bench for rx_des_param: frame-level outcome model with per-cycle pulse checking, plus directed checks.
module tb_rx_des_param;
   localparam int DIV_LS = 9;
   localparam int DIV_HS = 3;
`ifdef RX_DES_PARITY_EN
   localparam int LAT_LS = 106;
   localparam int LAT_HS = 43;
`else
   localparam int LAT_LS = 96;
   localparam int LAT_HS = 39;
`endif

   typedef struct {
      int         due;
      logic [3:0] kind;   // {err_parity, err_frame, rx_break, data_clk}
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] div_ls = 16'(DIV_LS);
   logic [15:0] div_hs = 16'(DIV_HS);
   logic [7:0]  idle_wait_len = 8'd10;
   logic        parity_odd = 1'b0;
   logic        force_wait_idle = 1'b0;
   logic        force9 = 1'b0;
   logic        rx = 1'b1;
   logic        rx9 = 1'b1;
   logic        bus_idle, data_clk, rx_break, err_frame, err_parity;
   logic [7:0]  data;
   logic        bus_idle9, data_clk9, rx_break9, err_frame9, err_parity9;
   logic [8:0]  data9;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   int   pulse_cyc[$];

   rx_des_param #(.DATA_BITS(8), .IDLE_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .div_ls(div_ls), .div_hs(div_hs),
      .idle_wait_len(idle_wait_len), .parity_odd(parity_odd),
      .force_wait_idle(force_wait_idle), .rx(rx), .bus_idle(bus_idle),
      .data(data), .data_clk(data_clk), .rx_break(rx_break),
      .err_frame(err_frame), .err_parity(err_parity));

   rx_des_param #(.DATA_BITS(9), .IDLE_W(8)) u_dut9 (
      .clk(clk), .reset_n(reset_n), .div_ls(div_ls), .div_hs(div_hs),
      .idle_wait_len(idle_wait_len), .parity_odd(parity_odd),
      .force_wait_idle(force9), .rx(rx9), .bus_idle(bus_idle9),
      .data(data9), .data_clk(data_clk9), .rx_break(rx_break9),
      .err_frame(err_frame9), .err_parity(err_parity9));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Frame outcome from the character-level rules: parity over data+parity bit, then stop level.
   function automatic logic [3:0] outcome(input logic [7:0] v, input logic stopb, input logic parb);
      logic pbad;
      pbad = ((^v ^ parb) != parity_odd);
`ifndef RX_DES_PARITY_EN
      pbad = 1'b0;
`endif
      if (stopb) return pbad ? 4'b1000 : 4'b0001;
      return (v == 8'h00 && !pbad) ? 4'b0010 : 4'b0100;
   endfunction

   task automatic compare_loop();
      logic [3:0] obs;
      forever begin
         @(negedge clk);
         obs = {err_parity, err_frame, rx_break, data_clk};
         if (reset_n) begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
               total++;
               if (obs != exp_q[0].kind || cyc != exp_q[0].due ||
                   (exp_q[0].kind[0] && data != exp_q[0].d)) begin
                  bad++;
                  $display("FAIL frame_pulse cyc=%0d got=%b data=%h want=%b data=%h due=%0d",
                           cyc, obs, data, exp_q[0].kind, exp_q[0].d, exp_q[0].due);
               end
               if (obs != 4'b0) pulse_cyc.push_back(cyc);
               void'(exp_q.pop_front());
            end else if (obs != 4'b0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse cyc=%0d got=%b want=0000", cyc, obs);
            end
         end
      end
   endtask

   task automatic wait_idle(input int which, input int maxc, output int n);
      n = 0;
      @(negedge clk);
      if (which == 0) rx = 1'b1; else rx9 = 1'b1;
      while (((which == 0) ? bus_idle : bus_idle9) !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("bus_idle%0d_reached", which), (n < maxc), 1);
   endtask

   // act: 0 none, 1 pulse force_wait_idle at bit act_k, 2 assert reset at bit act_k
   task automatic send(input int which, input int w, input logic [15:0] v, input bit hs,
                       input logic stopb, input logic parb, input int glitch_k,
                       input int act_k, input int act, input bit exp_en, output int t0);
      logic bits [0:19];
      logic lvl;
      int   n, div;
      exp_t e;
      div = hs ? DIV_HS : DIV_LS;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < w; i++) begin bits[n] = v[i]; n++; end
`ifdef RX_DES_PARITY_EN
      bits[n] = parb; n++;
`endif
      bits[n] = stopb; n++;
      @(negedge clk);
      t0 = cyc;
      if (which == 0 && exp_en) begin
         e.due  = t0 + 1 + (div + 1) * (n - 1) + div / 2 + 1;
         e.kind = outcome(v[7:0], stopb, parb);
         e.d    = v[7:0];
         exp_q.push_back(e);
      end
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c <= div; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            force_wait_idle = 1'b0;
            lvl = bits[k];
            if (k == glitch_k && c == div / 2 + 1) lvl = 1'b0;
            if (which == 0) rx = lvl; else rx9 = lvl;
            if (act != 0 && k == act_k && c == 0) begin
               if (act == 1) begin
                  force_wait_idle = 1'b1;
               end else begin
                  reset_n = 1'b0;
                  #1;
                  chk("midreset_pulses", {bus_idle, data_clk, rx_break, err_frame, err_parity}, 0);
                  chk("midreset_data", data, 0);
                  @(negedge clk);
                  rx = 1'b1;
                  reset_n = 1'b1;
                  return;
               end
            end
         end
      end
   endtask

   initial begin
      int n, t0, t1;
      fork
         compare_loop();
      join_none

      repeat (3) @(negedge clk);
      chk("reset_pulses", {bus_idle, data_clk, rx_break, err_frame, err_parity}, 0);
      chk("reset_data", data, 0);
      chk("reset_data9", data9, 0);
      reset_n = 1'b1;
      wait_idle(0, 300, n);
      chk("idle_after_10_bits", (n >= 95 && n <= 105), 1);

      // 0x5A at low rate then 0xC3 at high rate, back to back
      pulse_cyc.delete();
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b0, -1, -1, 0, 1'b1, t0);
      send(0, 8, 16'hC3, 1'b1, 1'b1, 1'b0, -1, -1, 0, 1'b1, t1);
      repeat (4) @(negedge clk);
      chk("b2b_data", data, 8'hC3);
      chk("b2b_pulses", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) begin
         chk("ls_latency", pulse_cyc[0] - t0, LAT_LS);
         chk("hs_latency", pulse_cyc[1] - t1, LAT_HS);
      end
      wait_idle(0, 600, n);

      // glitch at the data-bit-3 sample point must be voted out
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b0, 4, -1, 0, 1'b1, t0);
      wait_idle(0, 600, n);
      chk("glitch_data", data, 8'h5A);

      // break, then a frame that must be ignored while waiting for idle
      send(0, 8, 16'h00, 1'b0, 1'b0, 1'b0, -1, -1, 0, 1'b1, t0);
      send(0, 8, 16'h33, 1'b0, 1'b1, 1'b0, -1, -1, 0, 1'b0, t0);
      chk("break_not_idle", bus_idle, 0);
      wait_idle(0, 600, n);
      send(0, 8, 16'h01, 1'b0, 1'b0, 1'b0, -1, -1, 0, 1'b1, t0);
      wait_idle(0, 600, n);

`ifdef RX_DES_PARITY_EN
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b1, -1, -1, 0, 1'b1, t0);
      wait_idle(0, 600, n);
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b0, -1, -1, 0, 1'b1, t0);
      wait_idle(0, 600, n);
      parity_odd = 1'b1;
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b1, -1, -1, 0, 1'b1, t0);
      wait_idle(0, 600, n);
      chk("odd_parity_data", data, 8'h5A);
      parity_odd = 1'b0;
`endif

      // force_wait_idle at data bit 4 aborts the frame silently
      send(0, 8, 16'hA5, 1'b0, 1'b1, 1'b0, -1, 5, 1, 1'b0, t0);
      chk("force_not_idle", bus_idle, 0);
      wait_idle(0, 600, n);

      // nine-bit character on the wide instance
      wait_idle(1, 300, n);
      fork
         send(1, 9, 16'h1A5, 1'b0, 1'b1, 1'b1, -1, -1, 0, 1'b0, t1);
         begin
            n = 0;
            while (data_clk9 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
         end
      join
      chk("dut9_pulse", (n < 400), 1);
      chk("dut9_data", data9, 9'h1A5);

      // reset in the middle of data bit 3, then a clean frame
      send(0, 8, 16'h5A, 1'b0, 1'b1, 1'b0, -1, 4, 2, 1'b0, t0);
      wait_idle(0, 300, n);
      send(0, 8, 16'h3C, 1'b0, 1'b1, 1'b0, -1, -1, 0, 1'b1, t0);
      repeat (5) @(negedge clk);
      chk("after_reset_data", data, 8'h3C);
      chk("expectations_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
